// File: rtl/switch_debouncer.sv
// Switch/push-button conditioner: synchroniser, stability-counting FSM and
// registered level/edge outputs for the downstream NOT gate stage.
module switch_debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("switch_debouncer: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("switch_debouncer: STABLE_CYCLES must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_d, rise_d, fall_d, busy_d;
  logic                   commit_c;

  // Metastability synchroniser; only the last stage feeds the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // This sample is the last one needed to qualify the new level.
  assign commit_c = ((cnt_q + CNT_W'(1)) == CNT_W'(STABLE_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      db_out  <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_out  <= db_d;
      rise    <= rise_d;
      fall    <= fall_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_out;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      IDLE_LO: begin
        db_d = 1'b0;
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (commit_c) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          db_d    = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        db_d = 1'b1;
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (commit_c) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          db_d    = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        db_d    = 1'b0;
      end
    endcase

    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: default instance plus a
// SYNC_STAGES=3 / STABLE_CYCLES=8 instance, with a per-cycle expectation queue.
module tb_switch_debouncer;

  typedef struct packed {
    logic db;
    logic rise;
    logic fall;
    logic busy;
  } obs_t;

  logic clk;
  logic rst_a, sw_a, db_a, rise_a, fall_a, busy_a;
  logic rst_b, sw_b, db_b, rise_b, fall_b, busy_b;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  switch_debouncer dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .sw     (sw_a),
    .db_out (db_a),
    .rise   (rise_a),
    .fall   (fall_a),
    .busy   (busy_a)
  );

  switch_debouncer #(
    .SYNC_STAGES   (3),
    .STABLE_CYCLES (8)
  ) dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .sw     (sw_b),
    .db_out (db_b),
    .rise   (rise_b),
    .fall   (fall_b),
    .busy   (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs k edges after sw settles to a new level (edge 0 precedes the change).
  function automatic obs_t edge_exp(input int k, input int ns, input int nc, input bit to_hi);
    obs_t e;
    int   commit;
    commit = ns + nc;
    e.busy = (k > ns) && (k < commit);
    e.db   = to_hi ? (k >= commit) : (k < commit);
    e.rise = to_hi && (k == commit);
    e.fall = !to_hi && (k == commit);
    return e;
  endfunction

  function automatic obs_t mk(input logic db, input logic ri, input logic fa, input logic bu);
    obs_t e;
    e.db = db; e.rise = ri; e.fall = fa; e.busy = bu;
    return e;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input bit sel_b, input logic r, input logic s, input obs_t e,
                      input string tag);
    obs_t obs;
    obs_t want;
    if (sel_b) begin
      rst_b = r; sw_b = s;
    end else begin
      rst_a = r; sw_a = s;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs = sel_b ? {db_b, rise_b, fall_b, busy_b} : {db_a, rise_a, fall_a, busy_a};
    want = exp_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed db/rise/fall/busy=%b expected=%b", tag, obs, want);
    end
  endtask

  initial begin
    rst_a = 1'b1; sw_a = 1'b0;
    rst_b = 1'b1; sw_b = 1'b0;

    // Power-on reset and idle low
    step(0, 1'b1, 1'b0, mk(0, 0, 0, 0), "reset_a");
    step(0, 1'b1, 1'b0, mk(0, 0, 0, 0), "reset_a");
    for (int k = 0; k < 10; k++) step(0, 1'b0, 1'b0, mk(0, 0, 0, 0), "idle_lo");

    // Clean press then clean release
    for (int k = 1; k <= 9; k++) step(0, 1'b0, 1'b1, edge_exp(k, 2, 4, 1'b1), "press");
    for (int k = 1; k <= 9; k++) step(0, 1'b0, 1'b0, edge_exp(k, 2, 4, 1'b0), "release");

    // Three samples high is one short of qualifying
    for (int k = 1; k <= 10; k++) begin
      step(0, 1'b0, (k <= 3) ? 1'b1 : 1'b0,
           mk(0, 0, 0, (k >= 3 && k <= 5) ? 1'b1 : 1'b0), "bounce_reject");
    end

    // Bounce during qualification, then held high: count restarts
    for (int k = 1; k <= 12; k++) begin
      step(0, 1'b0, (k == 3) ? 1'b0 : 1'b1,
           mk((k >= 9) ? 1'b1 : 1'b0, (k == 9) ? 1'b1 : 1'b0, 1'b0,
              (k == 3 || k == 4 || (k >= 6 && k <= 8)) ? 1'b1 : 1'b0),
           "bounce_restart");
    end

    // Reset while qualifying a release, then full-latency press after release
    for (int k = 1; k <= 4; k++) begin
      step(0, 1'b0, 1'b0, mk(1, 0, 0, (k >= 3) ? 1'b1 : 1'b0), "pre_reset_wait");
    end
    step(0, 1'b1, 1'b1, mk(0, 0, 0, 0), "reset_mid_wait");
    for (int k = 1; k <= 9; k++) step(0, 1'b0, 1'b1, edge_exp(k, 2, 4, 1'b1), "press_after_reset");

    // Overridden parameters: latency 11, busy for 7 cycles
    step(1, 1'b1, 1'b0, mk(0, 0, 0, 0), "reset_b");
    step(1, 1'b1, 1'b0, mk(0, 0, 0, 0), "reset_b");
    for (int k = 0; k < 3; k++) step(1, 1'b0, 1'b0, mk(0, 0, 0, 0), "idle_b");
    for (int k = 1; k <= 14; k++) step(1, 1'b0, 1'b1, edge_exp(k, 3, 8, 1'b1), "press_b");
    for (int k = 1; k <= 14; k++) step(1, 1'b0, 1'b0, edge_exp(k, 3, 8, 1'b0), "release_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
